imem_fetch_unit: RTL and testbench

Parametrised, byte-addressed instruction memory with a registered fetch port, valid/ready handshake, response stall, fault reporting and a program-load write port. After reset it clears its own contents to NOP with a hardware init sweep. It sits between the core's PC/fetch stage and decode, and replaces the word-addressed, combinational, reset-initialised instruction ROM.

---
 rtl/imem_fetch_unit.sv | 126 ++++++++++++
 tb/tb_imem_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed instruction memory with a registered fetch
// port (valid/ready), response stall, fault reporting, a program-load write
// port, and a hardware sweep that fills every word with NOP after reset.
module imem_fetch_unit #(
  parameter int              XLEN   = 32,
  parameter int              DEPTH  = 64,
  parameter int              ADDR_W = 32,
  parameter logic [XLEN-1:0] NOP    = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_ready,
  output logic                       rsp_valid,
  output logic [XLEN-1:0]            rsp_instr,
  output logic                       rsp_fault,
  input  logic                       rsp_stall,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [XLEN-1:0]            load_data,
  output logic                       init_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AW-1:0]     cnt_r;
  logic [XLEN-1:0]   mem_r [DEPTH];

  logic              hold_s;
  logic              accept_s;
  logic              fault_s;
  logic [ADDR_W-1:0] addr_hi_s;
  logic [AW-1:0]     rd_idx_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [XLEN-1:0]   wdata_s;

  // A valid response under back-pressure must not be overwritten.
  assign hold_s      = rsp_valid && rsp_stall;
  assign fetch_ready = (state_r == ST_RUN) && !hold_s;
  assign accept_s    = fetch_req && fetch_ready;

  // Any byte-address bit above the word index range means out of range.
  assign addr_hi_s = fetch_addr >> (AW + 2);
  assign fault_s   = (fetch_addr[1:0] != 2'b00) || (addr_hi_s != {ADDR_W{1'b0}});
  assign rd_idx_s  = fetch_addr[AW+1:2];

  // Next-state logic: stay in INIT until the last word has been swept.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State, sweep counter and init_done; reset restarts the sweep at word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_INIT;
      cnt_r     <= {AW{1'b0}};
      init_done <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_INIT) begin
        cnt_r <= cnt_r + AW'(1);
      end
      init_done <= (state_nxt_s == ST_RUN);
    end
  end

  // Write-port mux: the sweep owns the port in INIT, program load in RUN.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {AW{1'b0}};
    wdata_s = {XLEN{1'b0}};
    if (state_r == ST_INIT) begin
      we_s    = 1'b1;
      waddr_s = cnt_r;
      wdata_s = NOP;
    end else begin
      we_s    = load_en;
      waddr_s = load_addr;
      wdata_s = load_data;
    end
  end

  // Memory array: no reset on the data path, only the sweep/load writes.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Registered response; reads old contents when a load hits the same word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP;
      rsp_fault <= 1'b0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_fault <= fault_s;
      rsp_instr <= fault_s ? NOP : mem_r[rd_idx_s];
    end else if (!hold_s) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam logic [31:0] NOPW = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        rsp_stall = 1'b0;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = 6'd0;
  logic [31:0] load_data = 32'h0;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb [$];   // {fault, instr}
  logic        pending = 1'b0;
  logic        held = 1'b0;

  imem_fetch_unit #(.XLEN(32), .DEPTH(64), .ADDR_W(32), .NOP(32'h00000013)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .rsp_stall(rsp_stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a response is due on the edge after an accept seen here.
  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0;
      held = 1'b0;
    end else begin
      if (pending) begin
        if (!rsp_valid) begin
          checks++; errors++;
          $display("FAIL rsp_valid_missing: actual=0 required=1");
        end else if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: actual=%h required=none", {rsp_fault, rsp_instr});
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          checks++;
          if ({rsp_fault, rsp_instr} !== e) begin
            errors++;
            $display("FAIL response: actual=%h required=%h", {rsp_fault, rsp_instr}, e);
          end
        end
      end else if (rsp_valid && !held) begin
        checks++; errors++;
        $display("FAIL spurious_valid: actual=1 required=0");
      end
      held = rsp_valid && rsp_stall;
      pending = fetch_req && fetch_ready;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_instr", 64'(rsp_instr), 64'(NOPW));
    reset = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_done && fetch_ready) begin
        checks++; errors++;
        $display("FAIL ready_in_init: actual=1 required=0");
      end
    end
    check("init_cycles", 64'(n), 64'd64);
    check("ready_after_init", 64'(fetch_ready), 64'd1);
  endtask

  task automatic load(input logic [5:0] idx, input logic [31:0] d);
    load_en = 1'b1; load_addr = idx; load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    int n = 0;
    fetch_req = 1'b1;
    fetch_addr = a;
    sb.push_back({ef, ei});
    @(negedge clk);
    while (!fetch_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: actual=%0d required=<50", n);
    end
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
  endtask

  initial begin
    // Reset and sweep; loads and fetches during INIT must be ignored.
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hBAD0_0BAD;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    do_reset();
    wait_init();
    load_en = 1'b0;
    fetch_req = 1'b0;
    fetch(32'h10, NOPW, 1'b0);
    fetch(32'h00, NOPW, 1'b0);

    // Program load then fetch.
    load(6'd0, 32'h00000093);
    load(6'd1, 32'h00100113);
    load(6'd2, 32'h00200193);
    load(6'd3, 32'h00208033);
    load(6'd5, 32'hAAAA0013);
    load(6'd63, 32'h0FC00013);
    fetch(32'h0C, 32'h00208033, 1'b0);
    check("rsp_valid_latency", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;

    // Faults and the last in-range word.
    fetch(32'h06, NOPW, 1'b1);
    fetch(32'h100, NOPW, 1'b1);
    fetch(32'hFC, 32'h0FC00013, 1'b0);
    fetch(32'h80000000, NOPW, 1'b1);
    @(posedge clk); #1;

    // Stall during the response to 0x4.
    fork
      begin
        fetch(32'h0, 32'h00000093, 1'b0);
        fetch(32'h4, 32'h00100113, 1'b0);
        fetch(32'h8, 32'h00200193, 1'b0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rsp_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_ready", 64'(fetch_ready), 64'd0);
          check("stall_hold", 64'({rsp_valid, rsp_fault, rsp_instr}), 64'({1'b1, 1'b0, 32'h00100113}));
        end
        @(posedge clk);
        #1;
        rsp_stall = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Read-before-write on word 5.
    load_en = 1'b1; load_addr = 6'd5; load_data = 32'h55550013;
    fetch(32'h14, 32'hAAAA0013, 1'b0);
    load_en = 1'b0;
    fetch(32'h14, 32'h55550013, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a response is valid.
    fetch(32'h0C, 32'h00208033, 1'b0);
    check("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_drop_valid", 64'(rsp_valid), 64'd0);
    sb.delete();
    do_reset();
    wait_init();
    fetch(32'h0C, NOPW, 1'b0);

    // Reset at sweep count 20.
    @(posedge clk); #1;
    reset = 1'b1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    check("mid_init_done", 64'(init_done), 64'd0);
    do_reset();
    wait_init();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
